// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: shape encodings, bag size, LFSR taps and the piece generator's FSM states.
package tetris_pkg;

    localparam int SHAPE_W    = 3;
    localparam int NUM_SHAPES = 7;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [SHAPE_W-1:0] SHAPE_O = 3'd0;
    localparam logic [SHAPE_W-1:0] SHAPE_I = 3'd1;
    localparam logic [SHAPE_W-1:0] SHAPE_T = 3'd2;
    localparam logic [SHAPE_W-1:0] SHAPE_L = 3'd3;
    localparam logic [SHAPE_W-1:0] SHAPE_J = 3'd4;
    localparam logic [SHAPE_W-1:0] SHAPE_S = 3'd5;
    localparam logic [SHAPE_W-1:0] SHAPE_Z = 3'd6;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } gen_state_e;

    // Lowest shape index whose bag bit is still clear; used to bound a draw to 8 attempts.
    function automatic logic [SHAPE_W-1:0] lowest_unused(input logic [NUM_SHAPES-1:0] used);
        logic [SHAPE_W-1:0] r;
        r = '0;
        for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
            if (!used[i]) r = SHAPE_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_galois16.sv
// 16-bit Galois LFSR that advances every cycle; load replaces the next value outright.
module lfsr_galois16
    import tetris_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        if (load) lfsr_d = load_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/piece_generator.sv
// 7-bag piece randomiser with a preview queue and valid/req handshake to the game FSM.
// Define PIECE_GEN_HOLD_EN to build in the hold slot (hold_req / hold_id / hold_valid).
module piece_generator
    import tetris_pkg::*;
#(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          PREVIEW_DEPTH = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req,
    input  logic                               seed_load,
    input  logic [15:0]                        seed_in,
    output logic [SHAPE_W-1:0]                 shape_id,
    output logic                               shape_valid,
    output logic [SHAPE_W*PREVIEW_DEPTH-1:0]   preview_ids
`ifdef PIECE_GEN_HOLD_EN
    ,
    input  logic                               hold_req,
    output logic [SHAPE_W-1:0]                 hold_id,
    output logic                               hold_valid
`endif
);

    localparam int QD = PREVIEW_DEPTH + 1;
    localparam int CW = $clog2(QD + 1);

    gen_state_e            state_q, state_d;
    logic [NUM_SHAPES-1:0] bag_q, bag_d;
    logic [CW-1:0]         count_q, count_d;
    logic [2:0]            rej_q, rej_d;
    logic [SHAPE_W-1:0]    queue_q [QD];
    logic [SHAPE_W-1:0]    queue_d [QD];
    logic                  valid_q, valid_d;

    logic [15:0]           lfsr;
    logic                  lfsr_unused;
    logic [SHAPE_W-1:0]    cand;
    logic [SHAPE_W-1:0]    draw_id;
    logic                  accept;
    logic                  do_pop;

`ifdef PIECE_GEN_HOLD_EN
    logic [SHAPE_W-1:0]    hold_id_q, hold_id_d;
    logic                  hold_valid_q, hold_valid_d;
`endif

    lfsr_galois16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .load_val ((seed_in == 16'h0000) ? SEED : seed_in),
        .q        (lfsr)
    );

    assign cand        = lfsr[SHAPE_W-1:0];
    assign lfsr_unused = ^lfsr[15:SHAPE_W];

    always_comb begin
        state_d = state_q;
        bag_d   = bag_q;
        count_d = count_q;
        rej_d   = rej_q;
        queue_d = queue_q;
        valid_d = valid_q;
        draw_id = lowest_unused(bag_q);
        accept  = 1'b0;
        do_pop  = 1'b0;
`ifdef PIECE_GEN_HOLD_EN
        hold_id_d    = hold_id_q;
        hold_valid_d = hold_valid_q;
`endif

        if (seed_load) begin
            state_d = ST_FILL;
            bag_d   = '0;
            count_d = '0;
            rej_d   = '0;
            valid_d = 1'b0;
            for (int i = 0; i < QD; i++) queue_d[i] = '0;
`ifdef PIECE_GEN_HOLD_EN
            hold_valid_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_FILL: begin
                    // Seven straight rejects fall back to the lowest unused shape.
                    if (rej_q == 3'd7) begin
                        accept = 1'b1;
                    end else if (cand != 3'd7 && !bag_q[cand]) begin
                        accept  = 1'b1;
                        draw_id = cand;
                    end else begin
                        rej_d = rej_q + 3'd1;
                    end

                    if (accept) begin
                        for (int i = 0; i < QD; i++) begin
                            if (count_q == CW'(i)) queue_d[i] = draw_id;
                        end
                        rej_d   = '0;
                        bag_d   = bag_q | (NUM_SHAPES'(1) << draw_id);
                        if (&bag_d) bag_d = '0;
                        count_d = count_q + CW'(1);
                        if (count_q == CW'(QD - 1)) begin
                            valid_d = 1'b1;
                            state_d = ST_READY;
                        end
                    end
                end

                ST_READY: begin
`ifdef PIECE_GEN_HOLD_EN
                    // hold_req takes precedence over a simultaneous req.
                    if (hold_req) begin
                        hold_id_d = queue_q[0];
                        if (hold_valid_q) begin
                            queue_d[0] = hold_id_q;
                        end else begin
                            hold_valid_d = 1'b1;
                            do_pop       = 1'b1;
                        end
                    end else if (req) begin
                        do_pop = 1'b1;
                    end
`else
                    if (req) do_pop = 1'b1;
`endif
                    if (do_pop) begin
                        for (int i = 0; i < QD - 1; i++) queue_d[i] = queue_q[i+1];
                        queue_d[QD-1] = '0;
                        count_d       = count_q - CW'(1);
                        valid_d       = 1'b0;
                        state_d       = ST_FILL;
                    end
                end

                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            bag_q   <= '0;
            count_q <= '0;
            rej_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < QD; i++) queue_q[i] <= '0;
        end else begin
            state_q <= state_d;
            bag_q   <= bag_d;
            count_q <= count_d;
            rej_q   <= rej_d;
            valid_q <= valid_d;
            queue_q <= queue_d;
        end
    end

`ifdef PIECE_GEN_HOLD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_id_q    <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_id_q    <= hold_id_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign hold_id    = hold_id_q;
    assign hold_valid = hold_valid_q;
`endif

    assign shape_id    = queue_q[0];
    assign shape_valid = valid_q;

    for (genvar gi = 0; gi < PREVIEW_DEPTH; gi++) begin : g_preview
        assign preview_ids[SHAPE_W*gi +: SHAPE_W] = queue_q[gi+1];
    end

endmodule

// File: tb/tb_piece_generator.sv
// Self-checking bench for piece_generator: randomized stimulus against a queue/bag reference model.
module tb_piece_generator;

    localparam int          D    = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          seed_load = 1'b0;
    logic [15:0]   seed_in = 16'h0;
    logic [2:0]    shape_id;
    logic          shape_valid;
    logic [3*D-1:0] preview_ids;
`ifdef PIECE_GEN_HOLD_EN
    logic          hold_req = 1'b0;
    logic [2:0]    hold_id;
    logic          hold_valid;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] trace [36];

    always #5 clk = ~clk;

    piece_generator #(
        .SEED          (SEED),
        .PREVIEW_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .shape_id    (shape_id),
        .shape_valid (shape_valid),
        .preview_ids (preview_ids)
`ifdef PIECE_GEN_HOLD_EN
        ,
        .hold_req    (hold_req),
        .hold_id     (hold_id),
        .hold_valid  (hold_valid)
`endif
    );

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    bit   [6:0]  m_used;
    int          m_rej;
    logic [2:0]  m_q [$];
    bit          m_valid;
    logic [2:0]  m_hold;
    bit          m_hold_v;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [2:0] exp_head();
        return (m_q.size() > 0) ? m_q[0] : 3'd0;
    endfunction

    function automatic logic [3*D-1:0] exp_preview();
        logic [3*D-1:0] r;
        r = '0;
        for (int k = 0; k < D; k++) if (m_q.size() > k + 1) r[3*k +: 3] = m_q[k+1];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [2:0] pick;
        bit         ok;
        logic [15:0] nxt;
        if (rst) begin
            m_lfsr = SEED; m_used = '0; m_rej = 0; m_q.delete();
            m_valid = 0; m_hold = 3'd0; m_hold_v = 0;
        end else begin
            nxt = lfsr_next(m_lfsr);
            if (seed_load) begin
                nxt = (seed_in == 16'h0) ? SEED : seed_in;
                m_used = '0; m_rej = 0; m_q.delete(); m_valid = 0; m_hold_v = 0;
            end else if (m_valid) begin
`ifdef PIECE_GEN_HOLD_EN
                if (hold_req) begin
                    if (m_hold_v) begin
                        pick = m_q[0]; m_q[0] = m_hold; m_hold = pick;
                    end else begin
                        m_hold = m_q[0]; m_hold_v = 1;
                        void'(m_q.pop_front()); m_valid = 0;
                    end
                end else
`endif
                if (req) begin
                    void'(m_q.pop_front()); m_valid = 0;
                end
            end else begin
                ok = 0; pick = 3'd0;
                if (m_rej == 7) begin
                    for (int s = 6; s >= 0; s--) if (!m_used[s]) pick = 3'(s);
                    ok = 1;
                end else if (m_lfsr[2:0] != 3'd7 && !m_used[m_lfsr[2:0]]) begin
                    pick = m_lfsr[2:0]; ok = 1;
                end else begin
                    m_rej++;
                end
                if (ok) begin
                    m_q.push_back(pick);
                    m_used[pick] = 1'b1;
                    m_rej = 0;
                    if (m_used == 7'h7F) m_used = '0;
                    if (m_q.size() == D + 1) m_valid = 1;
                end
            end
            m_lfsr = nxt;
        end
    end

    task automatic wait_valid(output bit ok);
        for (int k = 0; k < 40 && shape_valid !== 1'b1; k++) @(negedge clk);
        ok = (shape_valid === 1'b1);
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first;
        logic [2:0] e [4];
        bit distinct;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({shape_valid, shape_id, preview_ids} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_state got v=%b id=%0d pv=%h want all zero", shape_valid, shape_id, preview_ids);
        end
        rst = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            trace[i] = {shape_valid, shape_id, preview_ids};
            n_cmp++;
            if (trace[i] !== {m_valid, exp_head(), exp_preview()}) begin
                n_bad++;
                $display("FAIL reset_trace cyc=%0d got %h want %h", i, trace[i], {m_valid, exp_head(), exp_preview()});
            end
        end
        first = -1;
        for (int i = 0; i < 36; i++) if (first < 0 && trace[i][12]) first = i;
        n_cmp++;
        if (first < 0 || first > 31) begin
            n_bad++;
            $display("FAIL fill_latency got first_valid_cycle=%0d want <=31", first);
        end
        e[0] = trace[35][11:9]; e[1] = trace[35][2:0]; e[2] = trace[35][5:3]; e[3] = trace[35][8:6];
        distinct = 1;
        for (int a = 0; a < 4; a++) begin
            if (e[a] == 3'd7) distinct = 0;
            for (int b = a + 1; b < 4; b++) if (e[a] == e[b]) distinct = 0;
        end
        n_cmp++;
        if (!distinct) begin
            n_bad++;
            $display("FAIL fill_distinct got %0d %0d %0d %0d want 4 distinct shapes <7", e[0], e[1], e[2], e[3]);
        end
        $display("reset: first valid after %0d cycles, queue %0d %0d %0d %0d", first + 1, e[0], e[1], e[2], e[3]);
    endtask

    task automatic test_bag();
        logic [2:0] seq [14];
        logic [7:0] seen;
        bit ok;
        for (int p = 0; p < 14; p++) begin
            wait_valid(ok);
            n_cmp++;
            if (!ok || shape_id !== exp_head()) begin
                n_bad++;
                $display("FAIL bag_piece p=%0d got v=%b id=%0d want v=1 id=%0d", p, shape_valid, shape_id, exp_head());
            end
            seq[p] = shape_id;
            $display("bag: piece %0d shape %0d", p + 1, shape_id);
            pulse_req();
        end
        for (int h = 0; h < 2; h++) begin
            seen = '0;
            for (int j = 0; j < 7; j++) seen[seq[7*h + j]] = 1'b1;
            n_cmp++;
            if (seen !== 8'h7F) begin
                n_bad++;
                $display("FAIL bag_perm bag=%0d got set=%h want 7f", h, seen);
            end
        end
    endtask

    task automatic test_req_latency();
        logic [2:0] old_p0;
        bit ok;
        int k;
        wait_valid(ok);
        old_p0 = preview_ids[2:0];
        pulse_req();
        n_cmp++;
        if (shape_valid !== 1'b0 || shape_id !== old_p0) begin
            n_bad++;
            $display("FAIL req_pop got v=%b id=%0d want v=0 id=%0d", shape_valid, shape_id, old_p0);
        end
        for (k = 0; k < 8 && shape_valid !== 1'b1; k++) @(negedge clk);
        n_cmp++;
        if (shape_valid !== 1'b1 || shape_id !== exp_head() || preview_ids !== exp_preview()) begin
            n_bad++;
            $display("FAIL req_refill got v=%b id=%0d pv=%h after %0d want v=1 id=%0d pv=%h", shape_valid,
                     shape_id, preview_ids, k, exp_head(), exp_preview());
        end
        $display("req_latency: refill took %0d cycles, head %0d", k + 1, shape_id);
    endtask

    task automatic test_req_ignored();
        logic [8:0] old_pv;
        bit ok;
        int k;
        wait_valid(ok);
        old_pv = preview_ids;
        pulse_req();
        for (k = 0; k < 10 && shape_valid !== 1'b1; k++) begin
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
        end
        n_cmp++;
        if (shape_valid !== 1'b1 || shape_id !== old_pv[2:0] || preview_ids[5:0] !== old_pv[8:3]) begin
            n_bad++;
            $display("FAIL req_ignored got v=%b id=%0d pv=%h want v=1 id=%0d pv[5:0]=%h", shape_valid, shape_id,
                     preview_ids, old_pv[2:0], old_pv[8:3]);
        end
        n_cmp++;
        if (shape_id !== exp_head() || preview_ids !== exp_preview()) begin
            n_bad++;
            $display("FAIL req_ignored_model got id=%0d pv=%h want id=%0d pv=%h", shape_id, preview_ids,
                     exp_head(), exp_preview());
        end
        $display("req_ignored: %0d extra reqs while refilling, head %0d", k, shape_id);
    endtask

    task automatic test_seed_reload();
        logic [12:0] obs;
        bit ok;
        int bad_here;
        wait_valid(ok);
        seed_in   = 16'h0;
        seed_load = 1'b1;
        req       = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        req       = 1'b0;
        n_cmp++;
        if (shape_valid !== 1'b0 || shape_id !== 3'd0 || preview_ids !== 9'd0) begin
            n_bad++;
            $display("FAIL seed_flush got v=%b id=%0d pv=%h want 0 0 0", shape_valid, shape_id, preview_ids);
        end
        bad_here = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            obs = {shape_valid, shape_id, preview_ids};
            n_cmp++;
            if (obs !== trace[i]) begin
                n_bad++; bad_here++;
                $display("FAIL seed_replay cyc=%0d got %h want %h", i, obs, trace[i]);
            end
        end
        $display("seed_reload: replay of post-reset sequence, %0d differing cycles", bad_here);
    endtask

    task automatic test_random();
        int pops;
        pops = 0;
        for (int c = 0; c < 400; c++) begin
            req       = ($urandom % 4 == 0);
            seed_load = ($urandom % 80 == 0);
            seed_in   = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
`ifdef PIECE_GEN_HOLD_EN
            hold_req  = ($urandom % 6 == 0);
`endif
            if (req && shape_valid) pops++;
            @(negedge clk);
            n_cmp++;
            if ({shape_valid, shape_id, preview_ids} !== {m_valid, exp_head(), exp_preview()}) begin
                n_bad++;
                $display("FAIL random cyc=%0d got v=%b id=%0d pv=%h want v=%b id=%0d pv=%h", c, shape_valid,
                         shape_id, preview_ids, m_valid, exp_head(), exp_preview());
            end
`ifdef PIECE_GEN_HOLD_EN
            n_cmp++;
            if (hold_valid !== m_hold_v || hold_id !== m_hold) begin
                n_bad++;
                $display("FAIL random_hold cyc=%0d got hv=%b hid=%0d want hv=%b hid=%0d", c, hold_valid,
                         hold_id, m_hold_v, m_hold);
            end
`endif
        end
        req = 1'b0; seed_load = 1'b0; seed_in = 16'h0;
`ifdef PIECE_GEN_HOLD_EN
        hold_req = 1'b0;
`endif
        $display("random: 400 cycles, %0d reqs while valid", pops);
    endtask

    task automatic test_async_reset();
        bit ok;
        wait_valid(ok);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({shape_valid, shape_id, preview_ids} !== 13'd0) begin
            n_bad++;
            $display("FAIL async_reset got v=%b id=%0d pv=%h want all zero", shape_valid, shape_id, preview_ids);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({shape_valid, shape_id, preview_ids} !== trace[i]) begin
                n_bad++;
                $display("FAIL async_reset_replay cyc=%0d got %h want %h", i, {shape_valid, shape_id, preview_ids},
                         trace[i]);
            end
        end
        $display("async_reset: outputs cleared immediately, sequence restarted");
    endtask

`ifdef PIECE_GEN_HOLD_EN
    task automatic test_hold();
        logic [2:0] old_p0, old_head;
        bit ok, found;
        seed_in = 16'h1234;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        found = 0;
        for (int n = 0; n < 30 && !found; n++) begin
            wait_valid(ok);
            if (shape_id == 3'd2) found = 1;
            else pulse_req();
        end
        n_cmp++;
        if (!found || hold_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_setup got head=%0d hv=%b want head=2 hv=0", shape_id, hold_valid);
        end
        old_p0 = preview_ids[2:0];
        hold_req = 1'b1;
        @(negedge clk);
        hold_req = 1'b0;
        n_cmp++;
        if (hold_id !== 3'd2 || hold_valid !== 1'b1 || shape_valid !== 1'b0 || shape_id !== old_p0) begin
            n_bad++;
            $display("FAIL hold_first got hid=%0d hv=%b v=%b id=%0d want hid=2 hv=1 v=0 id=%0d", hold_id,
                     hold_valid, shape_valid, shape_id, old_p0);
        end
        wait_valid(ok);
        old_head = shape_id;
        hold_req = 1'b1;
        req      = 1'b1;
        @(negedge clk);
        hold_req = 1'b0;
        req      = 1'b0;
        n_cmp++;
        if (shape_valid !== 1'b1 || shape_id !== 3'd2 || hold_id !== old_head) begin
            n_bad++;
            $display("FAIL hold_swap got v=%b id=%0d hid=%0d want v=1 id=2 hid=%0d", shape_valid, shape_id,
                     hold_id, old_head);
        end
        $display("hold: held 2, swapped with %0d", old_head);
    endtask
`endif

    initial begin
        test_reset();
        test_bag();
        test_req_latency();
        test_req_ignored();
        test_seed_reload();
        test_random();
        test_async_reset();
`ifdef PIECE_GEN_HOLD_EN
        test_hold();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
